ps2_kbd_slave: RTL and testbench

- Read-side data-bus slave: a PS/2 keyboard receiver that the core polls or is interrupted by.
- Input-device counterpart of the write-only Vga/Timer0 slaves; it occupies a data-bus matrix slave port and uses the read channel (read address, read data, read-ready) as well as the write channel.
- Deserialises PS/2 frames into an 8-bit scancode FIFO, exposes DATA/STATUS/CTRL registers, and raises a level interrupt while scancodes are pending.

---
 rtl/ps2_kbd_slave_if.sv | 25 ++
 rtl/ps2_kbd_slave.sv | 189 ++++++++++++++++++
 tb/tb_ps2_kbd_slave.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_slave_if.sv
// Bus-matrix slave channel bundle for ps2_kbd_slave: read and write request/response signals.
interface ps2_kbd_slave_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] ReadAddrIn;
  logic              ReadValidIn;
  logic [DATA_W-1:0] ReadDataOut;
  logic              SlaverReadReady;
  logic [ADDR_W-1:0] WriteAddrIn;
  logic [DATA_W-1:0] WriteDataIn;
  logic [3:0]        WriteStrb;
  logic              WriteValidIn;
  logic              SlaverWriteReady;

  modport slave (
    input  ReadAddrIn, ReadValidIn, WriteAddrIn, WriteDataIn, WriteStrb, WriteValidIn,
    output ReadDataOut, SlaverReadReady, SlaverWriteReady
  );

  modport master (
    output ReadAddrIn, ReadValidIn, WriteAddrIn, WriteDataIn, WriteStrb, WriteValidIn,
    input  ReadDataOut, SlaverReadReady, SlaverWriteReady
  );
endinterface

// File: rtl/ps2_kbd_slave.sv
// PS/2 keyboard receiver on a bus-matrix slave port: scancode FIFO, DATA/STATUS/CTRL regs, level IRQ.
// Define PS2_PARITY_CHECK_EN to enforce odd parity on received frames.
module ps2_kbd_slave #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  ps2_kbd_slave_if.slave       bus,
  input  logic                 Ps2Clk,
  input  logic                 Ps2Data,
  output logic                 KbdIntOut
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic [2:0]        clkSync, datSync;
  logic              fall;
  logic [1:0]        state;
  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
  logic              parityBit;
  logic [11:0]       wdCnt;
  logic              timeout;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [AW:0]       cnt;
  logic              empty, full;
  logic              ovf, ferr;
  logic [1:0]        ctrl;

  logic [1:0]        rdSel, wrSel;
  logic              pop, frameDone, frameOk, parityOk, push, pushAccept;
  logic              wrStatus, wrCtrl;
  logic [DATA_W-1:0] rdMux, rdData;
  logic [3:0]        cntDisp;
  logic [31:0]       cntExt;
  logic [1:0]        rdVldPipe, wrVldPipe;

  assign fall    = ~clkSync[1] & clkSync[2];
  assign empty   = (cnt == '0);
  assign full    = (32'(cnt) == FIFO_DEPTH);
  assign rdSel   = bus.ReadAddrIn[4:3];
  assign wrSel   = bus.WriteAddrIn[4:3];
  assign pop     = bus.ReadValidIn && (rdSel == REG_DATA) && !empty;
  assign wrStatus = bus.WriteValidIn && (wrSel == REG_STATUS);
  assign wrCtrl   = bus.WriteValidIn && (wrSel == REG_CTRL);

`ifdef PS2_PARITY_CHECK_EN
  assign parityOk = ^{shiftReg, parityBit};
`else
  assign parityOk = 1'b1;
`endif

  // datSync[1] is aligned with the clock stage that produced the falling edge
  assign frameDone  = ctrl[0] && fall && (state == STOP);
  assign frameOk    = datSync[1] && parityOk;
  assign push       = frameDone && frameOk;
  assign pushAccept = push && (!full || pop);
  assign timeout    = ctrl[0] && (state != IDLE) && !fall && (wdCnt == 12'hFFF);

  assign cntExt  = 32'(cnt);
  assign cntDisp = (cntExt > 32'd15) ? 4'hF : cntExt[3:0];

  always_comb begin
    rdMux = '0;
    case (rdSel)
      REG_DATA: if (!empty) rdMux[8:0] = {1'b1, mem[rdPtr]};
      REG_STATUS: begin
        rdMux[0]   = !empty;
        rdMux[1]   = ovf;
        rdMux[2]   = ferr;
        rdMux[7:4] = cntDisp;
      end
      REG_CTRL: rdMux[1:0] = ctrl;
      default: rdMux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      clkSync <= 3'b111;
      datSync <= 3'b111;
    end else begin
      clkSync <= {clkSync[1:0], Ps2Clk};
      datSync <= {datSync[1:0], Ps2Data};
    end
  end

  // Receive FSM; disabling receive abandons the frame silently
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      wdCnt     <= '0;
    end else begin
      if (!ctrl[0] || state == IDLE || fall) wdCnt <= '0;
      else                                  wdCnt <= wdCnt + 12'd1;
      if (!ctrl[0] || timeout) begin
        state  <= IDLE;
        bitCnt <= '0;
      end else if (fall) begin
        case (state)
          IDLE: if (!datSync[1]) begin
            state  <= DATA;
            bitCnt <= '0;
          end
          DATA: begin
            shiftReg <= {datSync[1], shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parityBit <= datSync[1];
            state     <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (pushAccept) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      ferr  <= 1'b0;
      ctrl  <= '0;
    end else begin
      if (pushAccept) wrPtr <= wrPtr + 1'b1;
      if (pop)        rdPtr <= rdPtr + 1'b1;
      case ({pushAccept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // clears come first so a same-cycle event still latches the flag
      if (wrStatus && bus.WriteDataIn[1]) ovf  <= 1'b0;
      if (wrStatus && bus.WriteDataIn[2]) ferr <= 1'b0;
      if (push && full && !pop)           ovf  <= 1'b1;
      if ((frameDone && !frameOk) || timeout) ferr <= 1'b1;
      if (wrCtrl) ctrl <= bus.WriteDataIn[1:0];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rdVldPipe            <= '0;
      wrVldPipe            <= '0;
      rdData               <= '0;
      bus.ReadDataOut      <= '0;
      bus.SlaverReadReady  <= 1'b0;
      bus.SlaverWriteReady <= 1'b0;
      KbdIntOut            <= 1'b0;
    end else begin
      rdVldPipe <= {rdVldPipe[0], bus.ReadValidIn};
      wrVldPipe <= {wrVldPipe[0], bus.WriteValidIn};
      if (bus.ReadValidIn) rdData <= rdMux;
      if (rdVldPipe[0])    bus.ReadDataOut <= rdData;
      bus.SlaverReadReady  <= rdVldPipe[0];
      bus.SlaverWriteReady <= wrVldPipe[0];
      KbdIntOut            <= ctrl[1] && !empty;
    end
  end

  logic unusedBits;
  assign unusedBits = ^{bus.WriteStrb, bus.ReadAddrIn[ADDR_W-1:5], bus.ReadAddrIn[2:0],
                        bus.WriteAddrIn[ADDR_W-1:5], bus.WriteAddrIn[2:0],
                        bus.WriteDataIn[DATA_W-1:3], datSync[2], rdVldPipe[1], wrVldPipe[1],
                        parityBit};
endmodule

// File: tb/tb_ps2_kbd_slave.sv
// Directed bench for ps2_kbd_slave: bus register access, PS/2 frame reception, FIFO edges, watchdog.
module tb_ps2_kbd_slave;
  logic ACLK = 1'b0;
  logic ARESETn;
  logic Ps2Clk, Ps2Data;
  logic KbdIntOut;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] d;

  ps2_kbd_slave_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ps2_kbd_slave #(.ADDR_W(64), .DATA_W(64), .FIFO_DEPTH(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus),
    .Ps2Clk(Ps2Clk), .Ps2Data(Ps2Data), .KbdIntOut(KbdIntOut)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic busRead(input logic [63:0] a, output logic [63:0] rd);
    @(negedge ACLK);
    bus.ReadAddrIn  = a;
    bus.ReadValidIn = 1'b1;
    @(posedge ACLK); #1;
    bus.ReadValidIn = 1'b0;
    chk("rdRdyEarly", {63'd0, bus.SlaverReadReady}, 64'd0);
    @(posedge ACLK); #1;
    chk("rdRdy", {63'd0, bus.SlaverReadReady}, 64'd1);
    rd = bus.ReadDataOut;
    @(posedge ACLK); #1;
    chk("rdRdyLate", {63'd0, bus.SlaverReadReady}, 64'd0);
  endtask

  task automatic busWrite(input logic [63:0] a, input logic [63:0] wd);
    @(negedge ACLK);
    bus.WriteAddrIn  = a;
    bus.WriteDataIn  = wd;
    bus.WriteValidIn = 1'b1;
    @(posedge ACLK); #1;
    bus.WriteValidIn = 1'b0;
    chk("wrRdyEarly", {63'd0, bus.SlaverWriteReady}, 64'd0);
    @(posedge ACLK); #1;
    chk("wrRdy", {63'd0, bus.SlaverWriteReady}, 64'd1);
  endtask

  task automatic sendBit(input logic b);
    @(negedge ACLK);
    Ps2Data = b;
    repeat (8) @(negedge ACLK);
    Ps2Clk = 1'b0;
    repeat (10) @(negedge ACLK);
    Ps2Clk = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~(^b) ^ badPar);
    sendBit(1'b1);
    repeat (5) @(negedge ACLK);
  endtask

  initial begin
    logic [7:0] lastByte;
    ARESETn = 1'b0;
    Ps2Clk = 1'b1; Ps2Data = 1'b1;
    bus.ReadAddrIn = '0; bus.ReadValidIn = 1'b0;
    bus.WriteAddrIn = '0; bus.WriteDataIn = '0; bus.WriteStrb = 4'hF; bus.WriteValidIn = 1'b0;
    repeat (3) @(posedge ACLK); #1;
    chk("rstRdData", bus.ReadDataOut, 64'd0);
    chk("rstRdRdy", {63'd0, bus.SlaverReadReady}, 64'd0);
    chk("rstWrRdy", {63'd0, bus.SlaverWriteReady}, 64'd0);
    chk("rstInt", {63'd0, KbdIntOut}, 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    busRead(64'h08, d); chk("rstStatus", d, 64'h0);
    busRead(64'h00, d); chk("rstData", d, 64'h0);
    busRead(64'h10, d); chk("rstCtrl", d, 64'h0);
    busRead(64'h18, d); chk("reg18", d, 64'h0);

    // single frame with interrupt enabled
    busWrite(64'h10, 64'h3);
    busRead(64'h10, d); chk("ctrlRb", d, 64'h3);
    sendFrame(8'h1C, 1'b0);
    busRead(64'h08, d); chk("st1C", d, 64'h11);
    chk("int1C", {63'd0, KbdIntOut}, 64'd1);
    busRead(64'h00, d); chk("data1C", d, 64'h11C);
    busRead(64'h08, d); chk("stEmpty", d, 64'h0);
    chk("intClr", {63'd0, KbdIntOut}, 64'd0);

    // overflow: nine frames into an eight-entry FIFO
    busWrite(64'h10, 64'h1);
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0);
    busRead(64'h08, d); chk("stOvf", d, 64'h83);
    chk("intMasked", {63'd0, KbdIntOut}, 64'd0);
    for (int i = 1; i <= 8; i++) begin
      busRead(64'h00, d); chk("drainOvf", d, 64'h100 + 64'(i));
    end
    busRead(64'h00, d); chk("drainEmpty", d, 64'h0);
    busWrite(64'h08, 64'h2);
    busRead(64'h08, d); chk("ovfClr", d, 64'h0);

    // wrong parity
    sendFrame(8'h5A, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    busRead(64'h08, d); chk("stParErr", d, 64'h4);
    busRead(64'h00, d); chk("dataParErr", d, 64'h0);
`else
    busRead(64'h00, d); chk("dataParIgn", d, 64'h15A);
    busRead(64'h08, d); chk("stParIgn", d, 64'h0);
`endif
    busWrite(64'h08, 64'h4);
    busRead(64'h08, d); chk("ferrClr", d, 64'h0);

    // watchdog on a truncated frame
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    repeat (5000) @(negedge ACLK);
    busRead(64'h08, d); chk("stWdog", d, 64'h4);
    sendFrame(8'h29, 1'b0);
    busRead(64'h08, d); chk("stAfterWdog", d, 64'h15);
    busRead(64'h00, d); chk("data29", d, 64'h129);
    busWrite(64'h08, 64'h4);

    // disabling receive mid-frame drops the frame without an error
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    busWrite(64'h10, 64'h0);
    busWrite(64'h10, 64'h1);
    sendFrame(8'h55, 1'b0);
    busRead(64'h08, d); chk("stAbandon", d, 64'h11);
    busRead(64'h00, d); chk("data55", d, 64'h155);

    // full FIFO, pop coincident with the final stop-bit edge
    for (int i = 0; i < 8; i++) sendFrame(8'h31 + 8'(i), 1'b0);
    busRead(64'h08, d); chk("stFull", d, 64'h81);
    lastByte = 8'h40;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(lastByte[i]);
    sendBit(~(^lastByte));
    @(negedge ACLK);
    Ps2Data = 1'b1;
    repeat (8) @(negedge ACLK);
    Ps2Clk = 1'b0;
    @(posedge ACLK);
    @(posedge ACLK);
    @(negedge ACLK);
    bus.ReadAddrIn  = 64'h00;
    bus.ReadValidIn = 1'b1;
    @(posedge ACLK); #1;
    bus.ReadValidIn = 1'b0;
    @(posedge ACLK); #1;
    chk("rdRdyCoinc", {63'd0, bus.SlaverReadReady}, 64'd1);
    chk("dataCoinc", bus.ReadDataOut, 64'h131);
    repeat (10) @(negedge ACLK);
    Ps2Clk = 1'b1;
    repeat (5) @(negedge ACLK);
    busRead(64'h08, d); chk("stCoinc", d, 64'h81);
    for (int i = 1; i < 8; i++) begin
      busRead(64'h00, d); chk("drainFull", d, 64'h131 + 64'(i));
    end
    busRead(64'h00, d); chk("dataLast", d, 64'h140);
    busRead(64'h00, d); chk("finalEmpty", d, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
